// File: rtl/io_uart_pkg.sv
// io_uart shared definitions: IO port offsets, STATUS bit positions and the
// TX/RX state encodings used by the UART peripheral.
// No ports; imported by io_uart and the bench-visible RTL.
package io_uart_pkg;

  // Port offsets from p_base_port
  localparam int OFF_DATA    = 0;
  localparam int OFF_STATUS  = 1;
  localparam int OFF_DIVISOR = 2;

  // STATUS register bit positions
  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_TX_BUSY      = 2;
  localparam int ST_RX_VALID     = 3;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_RX_FRAME_ERR = 5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // RX_BREAK holds after a bad stop bit until the line returns high.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/io_uart_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry an extra wrap bit.
// Latency: pushed data is visible on pop_data the cycle after the push.
// Backpressure: push while full is dropped unless a pop frees a slot that cycle.
// Ports: clk, reset (sync, active-high), push/push_data, pop/pop_data, full, empty.
module io_uart_fifo #(
  parameter int p_depth = 4,
  parameter int p_width = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [p_width-1:0] push_data,
  input  logic               pop,
  output logic [p_width-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(p_depth);

  logic [p_width-1:0] mem [p_depth];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Same index with differing wrap bits means the write pointer lapped the read pointer.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped UART on the CPU IO port: DATA/STATUS/DIVISOR registers, TX FIFO, RX holding byte.
// Latency: reads are combinational; TX line falls 2 edges after a DATA write into an idle UART.
// Backpressure: none on the bus; DATA writes to a full FIFO are dropped, RX overrun is flagged.
// Ports: i_w_clk, i_w_reset, i_w_io_oe/we/port/in (CPU IO), o_w_io_out (0 when unselected),
//        i_w_rx (async serial in), o_w_tx (serial out, idle high).
module io_uart
  import io_uart_pkg::*;
#(
  parameter int                      p_data_width      = 16,
  parameter int                      p_port_width      = 8,
  parameter logic [p_port_width-1:0] p_base_port       = 8'h10,
  parameter logic [p_data_width-1:0] p_default_divisor = 16'd868,
  parameter int                      p_fifo_depth      = 4
) (
  input  logic                    i_w_clk,
  input  logic                    i_w_reset,
  input  logic                    i_w_io_oe,
  input  logic                    i_w_io_we,
  input  logic [p_port_width-1:0] i_w_io_port,
  input  logic [p_data_width-1:0] i_w_io_in,
  output logic [p_data_width-1:0] o_w_io_out,
  input  logic                    i_w_rx,
  output logic                    o_w_tx
);

  localparam logic [p_port_width-1:0] PORT_DATA    = p_port_width'(p_base_port + OFF_DATA);
  localparam logic [p_port_width-1:0] PORT_STATUS  = p_port_width'(p_base_port + OFF_STATUS);
  localparam logic [p_port_width-1:0] PORT_DIVISOR = p_port_width'(p_base_port + OFF_DIVISOR);
  localparam logic [p_data_width-1:0] ONE          = p_data_width'(1);
  localparam logic [p_data_width-1:0] TWO          = p_data_width'(2);

  // ---------------- address decode / registers ----------------
  logic                    sel_data, sel_status, sel_div, rd_en, wr_en;
  logic [p_data_width-1:0] divisor, eff_div, status;

  assign sel_data   = (i_w_io_port == PORT_DATA);
  assign sel_status = (i_w_io_port == PORT_STATUS);
  assign sel_div    = (i_w_io_port == PORT_DIVISOR);
  assign wr_en      = i_w_io_we;
  assign rd_en      = i_w_io_oe && !i_w_io_we;   // a simultaneous write wins
  assign eff_div    = (divisor < TWO) ? TWO : divisor;

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset)             divisor <= p_default_divisor;
    else if (wr_en && sel_div) divisor <= i_w_io_in;
  end

  // ---------------- TX path ----------------
  tx_state_t               tx_state;
  logic [p_data_width-1:0] tx_cnt, tx_div;
  logic [2:0]              tx_bit;
  logic [7:0]              tx_shift, fifo_dout;
  logic                    tx_line, tx_full, tx_empty, tx_pop, tx_cnt_end, tx_busy;

  io_uart_fifo #(.p_depth(p_fifo_depth), .p_width(8)) u_tx_fifo (
    .clk(i_w_clk), .reset(i_w_reset),
    .push(wr_en && sel_data), .push_data(i_w_io_in[7:0]),
    .pop(tx_pop), .pop_data(fifo_dout),
    .full(tx_full), .empty(tx_empty)
  );

  assign tx_cnt_end = (tx_cnt == tx_div - ONE);
  assign tx_busy    = (tx_state != TX_IDLE);
  // Pop from IDLE, or straight out of STOP so back-to-back frames have no gap.
  assign tx_pop     = !tx_empty && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt_end));
  assign o_w_tx     = tx_line;

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= p_default_divisor;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      // Line follows the state one cycle later, keeping every bit exactly tx_div long.
      tx_line <= (tx_state == TX_START) ? 1'b0 :
                 (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_state <= TX_START;
            tx_shift <= fifo_dout;
            tx_div   <= eff_div;
            tx_cnt   <= '0;
          end
        end
        TX_START: begin
          if (tx_cnt_end) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
          end else tx_cnt <= tx_cnt + ONE;
        end
        TX_DATA: begin
          if (tx_cnt_end) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
            else                tx_bit   <= tx_bit + 3'd1;
          end else tx_cnt <= tx_cnt + ONE;
        end
        TX_STOP: begin
          if (tx_cnt_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_state <= TX_START;
              tx_shift <= fifo_dout;
              tx_div   <= eff_div;
            end else tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt + ONE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  rx_state_t               rx_state;
  logic [p_data_width-1:0] rx_cnt, rx_div;
  logic [2:0]              rx_bit;
  logic [7:0]              rx_shift, rx_byte;
  logic                    rx_s1, rx_s2, rx_prev;
  logic                    rx_valid, rx_overrun, rx_frame_err;
  logic                    rx_bit_end, rx_half_end, rx_done, rx_bad_stop, rd_data;

  assign rx_bit_end  = (rx_cnt == rx_div - ONE);
  assign rx_half_end = (rx_cnt == (rx_div >> 1) - ONE);
  assign rx_done     = (rx_state == RX_STOP) && rx_bit_end && rx_s2;
  assign rx_bad_stop = (rx_state == RX_STOP) && rx_bit_end && !rx_s2;
  assign rd_data     = rd_en && sel_data;

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_w_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_div       <= p_default_divisor;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (wr_en && sel_status) begin
        if (i_w_io_in[ST_RX_OVERRUN])   rx_overrun   <= 1'b0;
        if (i_w_io_in[ST_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
      end
      // A DATA read in the completion cycle consumes the old byte, so the new one loads cleanly.
      if (rx_done) begin
        if (!rx_valid || rd_data) begin
          rx_byte  <= rx_shift;
          rx_valid <= 1'b1;
        end else rx_overrun <= 1'b1;
      end else if (rd_data) rx_valid <= 1'b0;
      if (rx_bad_stop) rx_frame_err <= 1'b1;

      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_div   <= eff_div;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_half_end) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + ONE;
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + ONE;
        end
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_BREAK;
          end else rx_cnt <= rx_cnt + ONE;
        end
        RX_BREAK: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_TX_BUSY]      = tx_busy;
    status[ST_RX_VALID]     = rx_valid;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_RX_FRAME_ERR] = rx_frame_err;
    o_w_io_out              = '0;
    if (rd_en) begin
      if (sel_data)        o_w_io_out = p_data_width'(rx_byte);
      else if (sel_status) o_w_io_out = status;
      else if (sel_div)    o_w_io_out = divisor;
    end
  end

endmodule

// File: tb/tb_io_uart.sv
`timescale 1ns/1ps
module tb_io_uart;

  localparam logic [7:0] P_DATA   = 8'h10;
  localparam logic [7:0] P_STATUS = 8'h11;
  localparam logic [7:0] P_DIV    = 8'h12;

  logic        clk = 1'b0;
  logic        reset, oe, we, rx, tx;
  logic [7:0]  port;
  logic [15:0] din, dout;

  always #5 clk = ~clk;

  io_uart dut (
    .i_w_clk(clk), .i_w_reset(reset), .i_w_io_oe(oe), .i_w_io_we(we),
    .i_w_io_port(port), .i_w_io_in(din), .o_w_io_out(dout),
    .i_w_rx(rx), .o_w_tx(tx)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int frames_seen = 0;
  int contig = 0;
  int last_start = -1000;
  logic mon_en = 1'b1;
  logic [7:0] sb_tx[$];
  logic [7:0] sb_rx[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // All drive tasks start and end just after a negedge.
  task automatic io_write(logic [7:0] p, logic [15:0] d);
    we = 1'b1; port = p; din = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic peek(logic [7:0] p, output logic [15:0] d);
    oe = 1'b1; port = p;
    #1 d = dout;
    oe = 1'b0;
  endtask

  task automatic read_data_sb(string name);
    logic [15:0] d;
    logic [7:0]  e;
    oe = 1'b1; port = P_DATA;
    #1 d = dout;
    @(negedge clk);
    oe = 1'b0;
    if (sb_rx.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: got %h, expected no pending rx byte", name, d);
    end else begin
      e = sb_rx.pop_front();
      check(name, d, {8'h00, e});
    end
  endtask

  task automatic send_rx(logic [7:0] b, logic stop_bit, int div);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (div) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  // TX monitor (divisor 4): decode frames at bit centres, compare against scoreboard.
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    int st;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        st = cyc;
        repeat (2) @(negedge clk);
        if (mon_en) check("tx_start_bit", 16'(tx), 16'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clk);
          b[k] = tx;
        end
        repeat (4) @(negedge clk);
        if (mon_en) begin
          check("tx_stop_bit", 16'(tx), 16'd1);
          if (sb_tx.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx_frame: got byte %h, expected no frame", b);
          end else begin
            e = sb_tx.pop_front();
            check("tx_byte", {8'h00, b}, {8'h00, e});
          end
          frames_seen++;
          if (st == last_start + 40) contig++;
          last_start = st;
        end
        @(negedge clk);
      end
    end
  end

  typedef struct {
    logic [7:0]  port;
    logic        oe;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vt[6];

  initial begin : main
    logic [15:0] d;
    logic [9:0]  fr;
    int base_f, base_c;
    logic saw_low;

    reset = 1'b1; oe = 1'b0; we = 1'b0; port = 8'h00; din = 16'h0; rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // ---- reset state: table-driven read decode ----
    check("reset_tx_idle", 16'(tx), 16'd1);
    vt[0] = '{P_STATUS, 1'b1, 16'h0002};
    vt[1] = '{P_DIV,    1'b1, 16'h0364};
    vt[2] = '{P_DATA,   1'b1, 16'h0000};
    vt[3] = '{P_STATUS, 1'b0, 16'h0000};
    vt[4] = '{8'h13,    1'b1, 16'h0000};
    vt[5] = '{8'h0F,    1'b1, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      oe = vt[i].oe; port = vt[i].port;
      #1 check($sformatf("reset_read_vec%0d", i), dout, vt[i].exp);
      @(negedge clk);
      oe = 1'b0;
    end

    // ---- single TX frame, exact bit timing ----
    io_write(P_DIV, 16'd4);
    peek(P_DIV, d);
    check("divisor_write", d, 16'd4);
    sb_tx.push_back(8'hA5);
    io_write(P_DATA, 16'h00A5);
    check("tx_latency_edge1", 16'(tx), 16'd1);
    @(negedge clk);
    check("tx_latency_edge2", 16'(tx), 16'd1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("tx_a5_clk%0d", i), 16'(tx), 16'(fr[i/4]));
      if (i % 4 == 1) begin
        peek(P_STATUS, d);
        check($sformatf("tx_busy_bit%0d", i/4), 16'(d[2]), 16'd1);
      end
    end
    repeat (3) @(negedge clk);
    check("tx_idle_after", 16'(tx), 16'd1);
    peek(P_STATUS, d);
    check("status_after_tx", d, 16'h0002);

    // ---- FIFO full: 6 back-to-back writes, 6th dropped ----
    base_f = frames_seen;
    base_c = contig;
    for (int b = 1; b <= 6; b++) begin
      if (b <= 5) sb_tx.push_back(8'(b));
      io_write(P_DATA, 16'(b));
    end
    peek(P_STATUS, d);
    check("fifo_full_status", d, 16'h0005);
    for (int c = 0; c < 400 && (frames_seen - base_f) < 5; c++) @(negedge clk);
    repeat (60) @(negedge clk);
    check("fifo_frame_count", 16'(frames_seen - base_f), 16'd5);
    check("fifo_contiguous", 16'(contig - base_c), 16'd4);
    check("tx_sb_drained", 16'(sb_tx.size()), 16'd0);
    peek(P_STATUS, d);
    check("status_after_burst", d, 16'h0002);

    // ---- RX loopback at divisor 8 ----
    io_write(P_DIV, 16'd8);
    sb_rx.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 8);
    peek(P_STATUS, d);
    check("rx_valid_set", d, 16'h000A);
    read_data_sb("rx_data_3c");
    peek(P_STATUS, d);
    check("rx_valid_cleared", d, 16'h0002);

    // ---- glitch shorter than half a bit is ignored ----
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    peek(P_STATUS, d);
    check("rx_glitch_ignored", d, 16'h0002);
    sb_rx.push_back(8'h81);
    send_rx(8'h81, 1'b1, 8);
    read_data_sb("rx_data_81");

    // ---- overrun keeps first byte ----
    sb_rx.push_back(8'h11);
    send_rx(8'h11, 1'b1, 8);
    send_rx(8'h22, 1'b1, 8);
    peek(P_STATUS, d);
    check("rx_overrun_status", d, 16'h001A);
    read_data_sb("rx_overrun_keep_first");
    peek(P_STATUS, d);
    check("rx_overrun_sticky", d, 16'h0012);

    // ---- frame error, then clear both flags ----
    send_rx(8'h55, 1'b0, 8);
    peek(P_STATUS, d);
    check("rx_frame_err_status", d, 16'h0032);
    io_write(P_STATUS, 16'h0030);
    peek(P_STATUS, d);
    check("flags_cleared", d, 16'h0002);
    check("rx_sb_drained", 16'(sb_rx.size()), 16'd0);

    // ---- reset during TX data bit 3 ----
    io_write(P_DIV, 16'd4);
    mon_en = 1'b0;
    io_write(P_DATA, 16'h0000);
    io_write(P_DATA, 16'h0000);
    io_write(P_DATA, 16'h0000);
    repeat (16) @(negedge clk);
    check("pre_reset_tx_low", 16'(tx), 16'd0);
    peek(P_STATUS, d);
    check("pre_reset_busy", 16'(d[2]), 16'd1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_tx_high_next", 16'(tx), 16'd1);
    reset = 1'b0;
    peek(P_STATUS, d);
    check("reset_mid_status", d, 16'h0002);
    peek(P_DIV, d);
    check("reset_mid_divisor", d, 16'h0364);
    saw_low = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("reset_fifo_flushed", 16'(saw_low), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
